// File: rtl/wb_master_cmd_pkg.sv
// Shared types and sizing helpers for the single-transfer Wishbone command initiator.
package wb_master_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RSP
    } state_e;

    // Timeout counter width; a disabled timeout (0) still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_master_cmd_if.sv
// Classic Wishbone bus bundle with initiator and target views.
interface wb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_master_cmd.sv
// Turns one valid/ready command into a single classic CYC/STB Wishbone cycle and
// returns data/status on a valid/ready response channel.
module wb_master_cmd
    import wb_master_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_adr,
    input  logic [DATA_WIDTH-1:0]   i_req_dat,
    input  logic [DATA_WIDTH/8-1:0] i_req_sel,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_dat,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout,
    output logic                    o_stray_ack,
    wb_if.master                    m
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_dat;
    logic                    r_rsp_err;
    logic                    r_rsp_timeout;
    logic                    r_stray;
    logic                    w_accept;
    logic                    w_err_end;
    logic                    w_ack_end;
    logic                    w_to_end;
    logic                    w_cnt_last;

    assign o_req_ready   = (r_state == ST_IDLE);
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_dat     = r_rsp_dat;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_stray_ack   = r_stray;

    // Counter holds the number of already-elapsed wait cycles; this edge is the last one.
    assign w_cnt_last = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_end   = 1'b0;
        w_ack_end   = 1'b0;
        w_to_end    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                if (m.err) begin
                    w_err_end   = 1'b1;
                    w_state_nxt = ST_RSP;
                end else if (m.ack) begin
                    w_ack_end   = 1'b1;
                    w_state_nxt = ST_RSP;
                end else if (w_cnt_last) begin
                    w_to_end    = 1'b1;
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m.cyc         <= 1'b0;
            m.stb         <= 1'b0;
            m.we          <= 1'b0;
            m.adr         <= '0;
            m.dat_w       <= '0;
            m.sel         <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_stray       <= 1'b0;
        end else begin
            if ((r_state != ST_BUS) && (m.ack || m.err)) begin
                r_stray <= 1'b1;
            end

            if (w_accept) begin
                m.we    <= i_req_we;
                m.adr   <= i_req_adr;
                m.dat_w <= i_req_dat;
                m.sel   <= i_req_sel;
                m.cyc   <= 1'b1;
                m.stb   <= 1'b1;
                r_cnt   <= '0;
            end

            if (w_err_end || w_ack_end || w_to_end) begin
                m.cyc       <= 1'b0;
                m.stb       <= 1'b0;
                r_rsp_valid <= 1'b1;
            end

            if (w_err_end) begin
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b0;
                r_rsp_dat     <= '0;
            end else if (w_ack_end) begin
                r_rsp_err     <= 1'b0;
                r_rsp_timeout <= 1'b0;
                r_rsp_dat     <= m.we ? '0 : m.dat_r;
            end else if (w_to_end) begin
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
                r_rsp_dat     <= '0;
            end else if ((r_state == ST_BUS) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == ST_RSP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Directed bench for wb_master_cmd with an in-bench configurable Wishbone responder.
module tb_wb_master_cmd;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        stray_ack;

    // Responder: rmode 0=silent, 1=ACK, 2=ERR, asserted when resp_cnt==resp_at.
    int          rmode = 1;
    int          resp_at = 1;
    int          resp_cnt = 0;
    logic        stray_drive = 1'b0;
    logic [31:0] rd_data = 32'hDEAD_BEEF;

    int total = 0;
    int bad = 0;

    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_master_cmd #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_we(req_we),
        .i_req_adr(req_adr),
        .i_req_dat(req_dat),
        .i_req_sel(req_sel),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_dat(rsp_dat),
        .o_rsp_err(rsp_err),
        .o_rsp_timeout(rsp_timeout),
        .o_stray_ack(stray_ack),
        .m(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) resp_cnt <= bus.cyc ? resp_cnt + 1 : 0;

    assign bus.ack   = stray_drive | ((rmode == 1) && bus.cyc && bus.stb && (resp_cnt == resp_at));
    assign bus.err   = (rmode == 2) && bus.cyc && bus.stb && (resp_cnt == resp_at);
    assign bus.dat_r = rd_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_cyc", bus.cyc, 1'b0);
        chk("rst_stb", bus.stb, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        chk("rst_stray", stray_ack, 1'b0);
        rstn = 1'b1;
        tick();
        chk("rst_req_ready", req_ready, 1'b1);

        // Read, zero-extra-wait ACK in the 2nd CYC cycle
        rmode = 1; resp_at = 1; rd_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_1000; req_sel = 4'hF;
        tick();
        req_valid = 1'b0;
        chk("rd_cyc_1", bus.cyc, 1'b1);
        chk("rd_stb_1", bus.stb, 1'b1);
        chk("rd_adr", bus.adr, 32'h0000_1000);
        chk("rd_we", bus.we, 1'b0);
        chk("rd_req_ready_busy", req_ready, 1'b0);
        tick();
        chk("rd_cyc_2", bus.cyc, 1'b1);
        chk("rd_no_rsp_yet", rsp_valid, 1'b0);
        tick();
        chk("rd_cyc_drop", bus.cyc, 1'b0);
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 1'b0);
        chk("rd_rsp_to", rsp_timeout, 1'b0);
        tick();
        chk("rd_rsp_done", rsp_valid, 1'b0);
        chk("rd_idle_ready", req_ready, 1'b1);

        // Write
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h0000_0004;
        req_dat = 32'h1234_5678; req_sel = 4'hF;
        tick();
        req_valid = 1'b0; req_dat = 32'hFFFF_0000;
        chk("wr_we", bus.we, 1'b1);
        chk("wr_dat_w", bus.dat_w, 32'h1234_5678);
        chk("wr_sel", bus.sel, 4'hF);
        tick();
        chk("wr_dat_w_stable", bus.dat_w, 32'h1234_5678);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_dat", rsp_dat, 32'h0);
        chk("wr_rsp_err", rsp_err, 1'b0);
        tick();

        // ERR in the 3rd CYC cycle
        rmode = 2; resp_at = 2;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_2000;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("err_cyc_still", bus.cyc, 1'b1);
        chk("err_ack_line", bus.err, 1'b1);
        tick();
        chk("err_cyc_drop", bus.cyc, 1'b0);
        chk("err_rsp_valid", rsp_valid, 1'b1);
        chk("err_rsp_err", rsp_err, 1'b1);
        chk("err_rsp_to", rsp_timeout, 1'b0);
        chk("err_rsp_dat", rsp_dat, 32'h0);
        tick();

        // Timeout with no responder: CYC high for 4 cycles
        rmode = 0;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        chk("to_cyc_c1", bus.cyc, 1'b1);
        tick();
        tick();
        tick();
        chk("to_cyc_c4", bus.cyc, 1'b1);
        chk("to_no_rsp_yet", rsp_valid, 1'b0);
        tick();
        chk("to_cyc_drop", bus.cyc, 1'b0);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_to", rsp_timeout, 1'b1);
        chk("to_rsp_dat", rsp_dat, 32'h0);
        tick();

        // Back-pressure on the response, next command held pending
        rmode = 1; resp_at = 1; rd_data = 32'hA5A5_0001; rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0020;
        tick();
        req_we = 1'b1; req_adr = 32'h0000_0040; req_dat = 32'h0000_0055;
        tick();
        tick();
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_dat", rsp_dat, 32'hA5A5_0001);
            chk("bp_hold_ready", req_ready, 1'b0);
            chk("bp_hold_cyc", bus.cyc, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", rsp_valid, 1'b0);
        chk("bp_idle", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("bp_next_cyc", bus.cyc, 1'b1);
        chk("bp_next_adr", bus.adr, 32'h0000_0040);
        chk("bp_next_we", bus.we, 1'b1);
        tick();
        tick();
        chk("bp_next_rsp", rsp_valid, 1'b1);
        chk("bp_next_dat", rsp_dat, 32'h0);
        tick();

        // ACK while CYC is low sets the sticky flag
        stray_drive = 1'b1;
        tick();
        stray_drive = 1'b0;
        chk("stray_set", stray_ack, 1'b1);
        tick();
        chk("stray_sticky", stray_ack, 1'b1);

        // Reset in the middle of a bus cycle
        rmode = 0;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_5000;
        tick();
        req_valid = 1'b0;
        chk("mid_cyc_up", bus.cyc, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_cyc_async", bus.cyc, 1'b0);
        chk("mid_stb_async", bus.stb, 1'b0);
        chk("mid_stray_clr", stray_ack, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
        chk("mid_no_rsp", rsp_valid, 1'b0);
        chk("mid_ready", req_ready, 1'b1);
        rmode = 1; resp_at = 1; rd_data = 32'hCAFE_F00D;
        req_valid = 1'b1; req_adr = 32'h0000_1000;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_rsp", rsp_valid, 1'b1);
        chk("post_rst_dat", rsp_dat, 32'hCAFE_F00D);
        chk("post_rst_err", rsp_err, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
